// File: rtl/fetch_pkg.sv
// Shared state encodings and constants for the fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    FETCH_S_IDLE     = 3'd0,
    FETCH_S_IMEM_REQ = 3'd1,
    FETCH_S_DISPATCH = 3'd2,
    FETCH_S_RETIRE   = 3'd3,
    FETCH_S_FAULT    = 3'd4
  } fetch_state_e;

  localparam int unsigned PC_INCREMENT     = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc.sv
// PC register with branch/sequential next-PC select and alignment handling.
// FETCH_MISALIGN_TRAP_EN keeps a misaligned target and flags it; otherwise bits [1:0] are cleared.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  branch_flag,
  input  logic [DATA_WIDTH-1:0] new_pc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  misalign
);

  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] raw_next;
  logic [ADDR_WIDTH-1:0] next_pc;

  assign target   = ADDR_WIDTH'(new_pc);
  assign raw_next = branch_flag ? target : pc + ADDR_WIDTH'(PC_INCREMENT);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign next_pc  = raw_next;
  assign misalign = |raw_next[1:0];
`else
  assign next_pc  = raw_next & ~ADDR_WIDTH'(3);
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/fetch.sv
// Single-issue instruction fetch: imem req/valid handshake, dispatch to decode, retire.
// FETCH_MISALIGN_TRAP_EN enables the sticky misaligned-target fault and S_FAULT.
//
// state            | meaning
// FETCH_S_IDLE     | waiting for halt low to start a fetch
// FETCH_S_IMEM_REQ | imem_req high at pc, waiting for imem_valid
// FETCH_S_DISPATCH | compute_req high, waiting for compute_valid
// FETCH_S_RETIRE   | waiting for compute_valid to drop
// FETCH_S_FAULT    | misaligned target trapped, held until reset
module fetch
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_valid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  compute_req,
  input  logic                  compute_valid,
  input  logic                  branch_flag,
  input  logic [DATA_WIDTH-1:0] new_pc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [31:0]           instret,
  output logic                  fetch_fault
);

  fetch_state_e state, state_next;
  logic         pc_load;
  logic         misalign;

  fetch_pc #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .RESET_PC  (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .load       (pc_load),
    .branch_flag(branch_flag),
    .new_pc     (new_pc),
    .pc         (pc),
    .misalign   (misalign)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH_S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    compute_req = 1'b0;
    pc_load     = 1'b0;
    case (state)
      FETCH_S_IDLE: begin
        if (!halt) state_next = FETCH_S_IMEM_REQ;
      end
      FETCH_S_IMEM_REQ: begin
        imem_req = 1'b1;
        if (imem_valid) state_next = FETCH_S_DISPATCH;
      end
      FETCH_S_DISPATCH: begin
        compute_req = 1'b1;
        if (compute_valid) begin
          pc_load    = 1'b1;
          state_next = misalign ? FETCH_S_FAULT : FETCH_S_RETIRE;
        end
      end
      // Holding here until compute_valid drops stops a stale valid retiring twice.
      FETCH_S_RETIRE: begin
        if (!compute_valid) state_next = FETCH_S_IDLE;
      end
      FETCH_S_FAULT: begin
        state_next = FETCH_S_FAULT;
      end
      default: state_next = FETCH_S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst    <= '0;
      instret <= '0;
    end else begin
      if (state == FETCH_S_IMEM_REQ && imem_valid) inst <= imem_rdata;
      if (pc_load) instret <= instret + 32'd1;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_fault <= 1'b0;
    end else if (pc_load && misalign) begin
      fetch_fault <= 1'b1;
    end
  end
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: sequential flow, branch, stale valid, wait states/halt,
// misaligned target (both FETCH_MISALIGN_TRAP_EN builds) and mid-fetch reset.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        compute_req;
  logic        compute_valid;
  logic        branch_flag;
  logic [31:0] new_pc;
  logic [31:0] pc;
  logic [31:0] instret;
  logic        fetch_fault;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret;

  fetch dut (
    .clk          (clk),
    .rst          (rst),
    .halt         (halt),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .inst         (inst),
    .compute_req  (compute_req),
    .compute_valid(compute_valid),
    .branch_flag  (branch_flag),
    .new_pc       (new_pc),
    .pc           (pc),
    .instret      (instret),
    .fetch_fault  (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_req_seen"}, 32'(imem_req), 32'd1);
  endtask

  task automatic do_instr(input string tag, input logic [31:0] addr, input logic [31:0] word,
                          input int waits, input int cv_cycles, input logic br,
                          input logic [31:0] tgt, input logic set_halt, input logic [31:0] exp_pc);
    wait_req(tag);
    chk({tag, "_addr"}, imem_addr, addr);
    if (set_halt) halt = 1'b1;
    for (int i = 0; i < waits; i++) begin
      step();
      chk({tag, "_wait_req"}, 32'(imem_req), 32'd1);
      chk({tag, "_wait_addr"}, imem_addr, addr);
    end
    imem_valid = 1'b1;
    imem_rdata = word;
    step();
    imem_valid = 1'b0;
    imem_rdata = 32'hdead_beef;
    chk({tag, "_creq_hi"}, 32'(compute_req), 32'd1);
    chk({tag, "_inst"}, inst, word);
    compute_valid = 1'b1;
    branch_flag   = br;
    new_pc        = tgt;
    step();
    branch_flag = 1'b0;
    new_pc      = 32'h0;
    exp_instret++;
    chk({tag, "_creq_lo"}, 32'(compute_req), 32'd0);
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_instret"}, instret, exp_instret);
    for (int i = 1; i < cv_cycles; i++) begin
      step();
      chk({tag, "_stale_creq"}, 32'(compute_req), 32'd0);
      chk({tag, "_stale_req"}, 32'(imem_req), 32'd0);
      chk({tag, "_stale_instret"}, instret, exp_instret);
      chk({tag, "_stale_pc"}, pc, exp_pc);
    end
    compute_valid = 1'b0;
    step();
    chk({tag, "_gap_req"}, 32'(imem_req), 32'd0);
  endtask

  initial begin
    rst           = 1'b0;
    halt          = 1'b1;
    imem_valid    = 1'b0;
    imem_rdata    = 32'h0;
    compute_valid = 1'b0;
    branch_flag   = 1'b0;
    new_pc        = 32'h0;
    exp_instret   = 32'd0;
    #12;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_creq", 32'(compute_req), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);

    step();
    rst  = 1'b1;
    halt = 1'b0;
    step();
    chk("first_req_latency", 32'(imem_req), 32'd1);

    do_instr("seq0", 32'h0, 32'h0000_0013, 0, 1, 1'b0, 32'h0, 1'b0, 32'h4);
    do_instr("seq1", 32'h4, 32'h0000_0013, 0, 1, 1'b0, 32'h0, 1'b0, 32'h8);
    do_instr("br",   32'h8, 32'h0000_0013, 0, 1, 1'b1, 32'h100, 1'b0, 32'h100);
    chk("seq_instret3", instret, 32'd3);

    do_instr("stale", 32'h100, 32'h0040_0093, 0, 3, 1'b0, 32'h0, 1'b0, 32'h104);
    chk("stale_instret", instret, 32'd4);

    do_instr("wait", 32'h104, 32'h0080_0113, 5, 1, 1'b0, 32'h0, 1'b1, 32'h108);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("halt_no_req", 32'(imem_req), 32'd0);
    end
    chk("halt_pc", pc, 32'h108);
    halt = 1'b0;

`ifdef FETCH_MISALIGN_TRAP_EN
    do_instr("mis", 32'h108, 32'h0000_0013, 0, 1, 1'b1, 32'h102, 1'b0, 32'h102);
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mis_no_req", 32'(imem_req), 32'd0);
    end
    chk("mis_pc_held", pc, 32'h102);
`else
    do_instr("mis", 32'h108, 32'h0000_0013, 0, 1, 1'b1, 32'h102, 1'b0, 32'h100);
    chk("mis_fault", 32'(fetch_fault), 32'd0);
    wait_req("mis_next");
    chk("mis_next_addr", imem_addr, 32'h100);
`endif

    rst = 1'b0;
    #1;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_creq", 32'(compute_req), 32'd0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_instret", instret, 32'd0);
    chk("mid_rst_fault", 32'(fetch_fault), 32'd0);
    exp_instret = 32'd0;
    step();
    rst = 1'b1;
    do_instr("restart", 32'h0, 32'h0000_0513, 0, 1, 1'b0, 32'h0, 1'b0, 32'h4);
    chk("restart_instret", instret, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
